// File: rtl/spi_cfg_pkg.sv
// Shared constants for the SPI configuration write path: frame layout,
// register map of the PWM/output-enable file, and sequencer state codes.
package spi_cfg_pkg;

    localparam int         SPI_FRAME_W   = 16;
    localparam logic       SPI_WRITE_BIT = 1'b1;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_PWM_EN_7_0  = 7'h02;
    localparam logic [6:0] ADDR_PWM_EN_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
    localparam logic [6:0] MAX_ADDR         = ADDR_PWM_DUTY;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEAD   = 3'd1;
    localparam state_t ST_BIT_LO = 3'd2;
    localparam state_t ST_BIT_HI = 3'd3;
    localparam state_t ST_TRAIL  = 3'd4;
    localparam state_t ST_GAP    = 3'd5;

    function automatic logic [SPI_FRAME_W-1:0] make_frame(input logic [6:0] addr,
                                                         input logic [7:0] data);
        return {SPI_WRITE_BIT, addr, data};
    endfunction

endpackage

// File: rtl/spi_cfg_write_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// wrapping; the pointer moves past the winner when advance_i is pulsed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o,
    output logic [2:0]   idx_o
);

    logic [2:0] ptr_q, ptr_d;
    logic       found;
    int         c;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_q) + k) % N;
            if (!found && req_i[c]) begin
                found      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = 3'(c);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i)
            ptr_d = (int'(idx_o) >= N - 1) ? 3'd0 : idx_o + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/spi_cfg_write_sequencer.sv
// Arbitrates NUM_REQ register-write requesters onto one SPI Mode-0 port,
// sending each accepted write as a 16-bit frame {1, addr, data}, MSB first.
module spi_cfg_write_sequencer #(
    parameter int         NUM_REQ  = 2,
    parameter int         CLK_DIV  = 4,
    parameter int         CS_GAP   = 8,
    parameter logic [6:0] MAX_ADDR = 7'h04
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 done,
    output logic [2:0]           done_id,
    output logic                 err,
    output logic                 busy,
    output logic                 ncs,
    output logic                 sclk,
    output logic                 copi
);
    import spi_cfg_pkg::*;

    // The half-period counter also times the inter-frame gap (CS_GAP <= 256).
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [4:0]             bit_q, bit_d;
    logic [SPI_FRAME_W-1:0] shreg_q, shreg_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic                   ncs_q, ncs_d, sclk_q, sclk_d, copi_q, copi_d;
    logic                   done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic                   bad_q, bad_d;
    logic [2:0]             id_q, id_d, done_id_q, done_id_d;

    logic [NUM_REQ-1:0]     grant;
    logic [2:0]             gidx;
    logic                   accept;
    logic                   cnt_wrap;
    logic [6:0]             sel_addr;
    logic [7:0]             sel_data;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .advance_i (accept),
        .grant_o   (grant),
        .idx_o     (gidx)
    );

    assign sel_addr = req_addr[7*gidx +: 7];
    assign sel_data = req_data[8*gidx +: 8];
    assign cnt_wrap = (cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        ready_d   = '0;
        ncs_d     = ncs_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        bad_d     = 1'b0;
        id_d      = id_q;
        done_id_d = done_id_q;
        accept    = 1'b0;

        if (bad_q) begin
            err_d     = 1'b1;
            done_id_d = id_q;
        end

        case (state_q)
            ST_IDLE: begin
                // The cycle that shows req_ready is the requester's last valid
                // cycle, so it must not be granted a second time.
                if (|req_valid && !(|ready_q)) begin
                    accept  = 1'b1;
                    ready_d = grant;
                    id_d    = gidx;
                    if (sel_addr > MAX_ADDR) begin
                        bad_d = 1'b1;
                    end else begin
                        shreg_d = make_frame(sel_addr, sel_data);
                        state_d = ST_LEAD;
                        cnt_d   = '0;
                        bit_d   = '0;
                        ncs_d   = 1'b0;
                        sclk_d  = 1'b0;
                        copi_d  = SPI_WRITE_BIT;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_LEAD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    state_d = ST_BIT_LO;
                end
            end
            ST_BIT_LO: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = ST_BIT_HI;
                end
            end
            ST_BIT_HI: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_wrap) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 5'd1;
                    if (bit_q == 5'd15) begin
                        state_d = ST_TRAIL;
                    end else begin
                        // copi moves together with the falling sclk edge only.
                        state_d = ST_BIT_LO;
                        shreg_d = shreg_q << 1;
                        copi_d  = shreg_q[SPI_FRAME_W-2];
                    end
                end
            end
            ST_TRAIL: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_wrap) begin
                    cnt_d     = '0;
                    ncs_d     = 1'b1;
                    copi_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            ready_q   <= '0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            bad_q     <= 1'b0;
            id_q      <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            ready_q   <= ready_d;
            ncs_q     <= ncs_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            bad_q     <= bad_d;
            id_q      <= id_d;
            done_id_q <= done_id_d;
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign ncs       = ncs_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;

endmodule

// File: tb/tb_spi_cfg_write_sequencer.sv
// Directed bench for spi_cfg_write_sequencer: a bus monitor rebuilds frames
// from ncs/sclk/copi and the main sequence compares them to hand-made values.
module tb_spi_cfg_write_sequencer;

    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [7*NR-1:0] req_addr = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            done, err, busy, ncs, sclk, copi;
    logic [2:0]      done_id;

    spi_cfg_write_sequencer #(.NUM_REQ(NR), .CLK_DIV(4), .CS_GAP(8), .MAX_ADDR(7'h04)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .done      (done),
        .done_id   (done_id),
        .err       (err),
        .busy      (busy),
        .ncs       (ncs),
        .sclk      (sclk),
        .copi      (copi)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bus monitor state, sampled on the falling clock edge.
    logic [15:0] frq[$];
    int          lowq[$], riseq[$], gapq[$], doneq[$], errq[$], accq[$], acct[$];
    logic [15:0] sh;
    int          low_cnt, high_cnt, nrise, viol, cyc;
    logic        p_ncs, p_sclk, p_copi;
    logic        rdy_busy, rdy_ncs;

    initial begin
        sh = '0; low_cnt = 0; high_cnt = 0; nrise = 0; viol = 0; cyc = 0;
        p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sh = '0; low_cnt = 0; high_cnt = 0; nrise = 0;
                p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
            end else begin
                if (!ncs) begin
                    if (p_ncs) gapq.push_back(high_cnt);
                    low_cnt++;
                    if (sclk && !p_sclk) begin
                        sh = {sh[14:0], copi};
                        nrise++;
                    end
                    if (sclk && p_sclk && (copi !== p_copi)) viol++;
                end else begin
                    if (!p_ncs) begin
                        frq.push_back(sh);
                        lowq.push_back(low_cnt);
                        riseq.push_back(nrise);
                        sh = '0; low_cnt = 0; nrise = 0; high_cnt = 0;
                    end
                    high_cnt++;
                end
                if (done) doneq.push_back(int'(done_id));
                if (err)  errq.push_back(int'(done_id));
                for (int i = 0; i < NR; i++)
                    if (req_ready[i]) begin
                        accq.push_back(i);
                        acct.push_back(cyc);
                    end
                p_ncs = ncs; p_sclk = sclk; p_copi = copi;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        frq.delete(); lowq.delete(); riseq.delete(); gapq.delete();
        doneq.delete(); errq.delete(); accq.delete(); acct.delete();
    endtask

    task automatic write(input int i, input logic [6:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        req_addr[7*i +: 7] = a;
        req_data[8*i +: 8] = d;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                rdy_busy = busy;
                rdy_ncs = ncs;
            end
        end
        req_valid[i] = 1'b0;
        chk($sformatf("ready%0d_seen", i), 32'(got), 32'd1);
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (doneq.size() >= target) ok = 1'b1;
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;

        // Reset values
        cycles(3);
        chk("rst_ncs", 32'(ncs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_copi", 32'(copi), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Single write: frame 0x82A5, ncs low 136 cycles
        clear_q();
        write(0, 7'h02, 8'hA5);
        chk("single_busy_at_ready", 32'(rdy_busy), 32'd1);
        chk("single_ncs_at_ready", 32'(rdy_ncs), 32'd0);
        wait_done(1);
        cycles(12);
        chk("single_frame", 32'(frq[0]), 32'h82A5);
        chk("single_ncs_low", 32'(lowq[0]), 32'd136);
        chk("single_rises", 32'(riseq[0]), 32'd16);
        chk("single_done_id", 32'(doneq[0]), 32'd0);
        chk("single_busy_after", 32'(busy), 32'd0);

        // Contention from reset, then repeated: order 0,1,0,1
        rst_n = 1'b0;
        cycles(1);
        clear_q();
        fork
            write(0, 7'h01, 8'h3C);
            write(1, 7'h03, 8'hC3);
            begin cycles(2); rst_n = 1'b1; end
        join
        fork
            write(0, 7'h01, 8'h3C);
            write(1, 7'h03, 8'hC3);
        join
        wait_done(4);
        cycles(12);
        chk("cont_acc_n", 32'(accq.size()), 32'd4);
        chk("cont_frame_n", 32'(frq.size()), 32'd4);
        if (accq.size() == 4 && frq.size() == 4 && doneq.size() == 4) begin
            chk("cont_acc0", 32'(accq[0]), 32'd0);
            chk("cont_acc1", 32'(accq[1]), 32'd1);
            chk("cont_acc2", 32'(accq[2]), 32'd0);
            chk("cont_acc3", 32'(accq[3]), 32'd1);
            chk("cont_frame0", 32'(frq[0]), 32'h813C);
            chk("cont_frame1", 32'(frq[1]), 32'h83C3);
            chk("cont_frame2", 32'(frq[2]), 32'h813C);
            chk("cont_frame3", 32'(frq[3]), 32'h83C3);
            chk("cont_done1", 32'(doneq[1]), 32'd1);
            chk("cont_done3", 32'(doneq[3]), 32'd1);
        end

        // Bad address on requester 1: ready, then err next cycle, bus idle
        clear_q();
        req_addr[13:7] = 7'h05;
        req_data[15:8] = 8'h11;
        req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[1]) ok = 1'b1;
        end
        req_valid[1] = 1'b0;
        chk("bad_ready_seen", 32'(ok), 32'd1);
        chk("bad_busy_at_ready", 32'(busy), 32'd0);
        chk("bad_err_early", 32'(err), 32'd0);
        cycles(1);
        chk("bad_err_pulse", 32'(err), 32'd1);
        chk("bad_err_id", 32'(done_id), 32'd1);
        cycles(1);
        chk("bad_err_one_cycle", 32'(err), 32'd0);
        cycles(3);
        chk("bad_ncs_idle", 32'(ncs), 32'd1);
        chk("bad_sclk_idle", 32'(sclk), 32'd0);
        chk("bad_no_bus", 32'(gapq.size()), 32'd0);
        write(0, 7'h04, 8'h7E);
        wait_done(1);
        cycles(12);
        chk("bad_next_frame_n", 32'(frq.size()), 32'd1);
        if (frq.size() == 1) chk("bad_next_frame", 32'(frq[0]), 32'h847E);
        chk("bad_err_count", 32'(errq.size()), 32'd1);

        // Reset after the 7th sclk rise
        clear_q();
        write(0, 7'h00, 8'hFF);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (nrise >= 7) ok = 1'b1;
        end
        chk("mid_rise7_seen", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ncs_async", 32'(ncs), 32'd1);
        chk("mid_sclk_async", 32'(sclk), 32'd0);
        chk("mid_busy_async", 32'(busy), 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        chk("mid_no_done", 32'(doneq.size()), 32'd0);
        chk("mid_no_frame", 32'(frq.size()), 32'd0);
        write(0, 7'h03, 8'h5A);
        wait_done(1);
        cycles(12);
        chk("mid_clean_frame_n", 32'(frq.size()), 32'd1);
        if (frq.size() == 1) begin
            chk("mid_clean_frame", 32'(frq[0]), 32'h835A);
            chk("mid_clean_low", 32'(lowq[0]), 32'd136);
        end

        // Back-to-back: one requester held valid for three writes
        clear_q();
        req_addr[6:0] = 7'h00;
        req_data[7:0] = 8'h01;
        req_valid[0] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            ok = 1'b0;
            for (int k = 0; k < 400 && !ok; k++) begin
                @(negedge clk);
                if (req_ready[0]) ok = 1'b1;
            end
            chk($sformatf("b2b_ready%0d", w), 32'(ok), 32'd1);
            req_addr[6:0] = 7'(w + 1);
            req_data[7:0] = 8'(w + 2);
        end
        req_valid[0] = 1'b0;
        wait_done(3);
        cycles(12);
        chk("b2b_frame_n", 32'(frq.size()), 32'd3);
        if (frq.size() == 3 && gapq.size() == 3 && acct.size() == 3) begin
            chk("b2b_frame0", 32'(frq[0]), 32'h8001);
            chk("b2b_frame1", 32'(frq[1]), 32'h8102);
            chk("b2b_frame2", 32'(frq[2]), 32'h8203);
            chk("b2b_gap1", 32'(gapq[1]), 32'd9);
            chk("b2b_gap2", 32'(gapq[2]), 32'd9);
            chk("b2b_acc_spacing1", 32'(acct[1] - acct[0]), 32'd145);
            chk("b2b_acc_spacing2", 32'(acct[2] - acct[1]), 32'd145);
        end
        chk("copi_stable_sclk_hi", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
